// File: rtl/ysyx_23060221_arbiter_if.sv
// AXI-style read/write bus bundle shared by the IFU, LSU and slave sides of the arbiter.
// No storage; pure wiring.
// Flow control is the usual valid/ready pair on every channel.
interface ysyx_23060221_arbiter_if;
  // read address
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready;
  // read data
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  logic        rready;
  // write address
  logic        awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awready;
  // write data
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wready;
  // write response
  logic        bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        bready;

  // side that issues requests
  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rresp, rlast, rid, output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp, bid, output bready
  );

  // side that answers requests
  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rlast, rid, input rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready
  );
endinterface

// File: rtl/ysyx_23060221_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave bus arbiter, one transaction at a time.
// Grant takes one edge from IDLE; granted channels pass through with zero added latency.
// Ungranted masters see ready=0; an idle cycle separates consecutive grants.
module ysyx_23060221_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_23060221_arbiter_if.slave   m0,
  ysyx_23060221_arbiter_if.slave   m1,
  ysyx_23060221_arbiter_if.master  s,
  output logic                     err_timeout
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2,
    WR_LSU = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          err_q, err_d;

  // State, hold counter and sticky error register; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // Next state: fixed priority in IDLE, otherwise wait for the granted release condition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m1.awvalid)      state_d = WR_LSU;
        else if (m1.arvalid) state_d = RD_LSU;
        else if (m0.arvalid) state_d = RD_IFU;
      end
      RD_IFU, RD_LSU: if (s.rvalid && s.rready && s.rlast) state_d = IDLE;
      WR_LSU:         if (s.bvalid && s.bready)            state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Hold counter saturates at TIMEOUT; the error flag latches when it gets there.
  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE)   hold_d = '0;
    else if (hold_q != TMAX) hold_d = hold_q + 1'b1;
    err_d = err_q | ((state_q != IDLE) && (hold_d == TMAX));
  end

  assign err_timeout = err_q;

  // Channel steering: everything is zero unless the current grant routes it.
  always_comb begin
    s.arvalid = 1'b0; s.araddr = '0; s.arid = '0; s.arlen = '0; s.arsize = '0; s.arburst = '0;
    s.rready  = 1'b0;
    s.awvalid = 1'b0; s.awaddr = '0; s.awid = '0; s.awlen = '0; s.awsize = '0; s.awburst = '0;
    s.wvalid  = 1'b0; s.wdata = '0; s.wstrb = '0; s.wlast = 1'b0;
    s.bready  = 1'b0;
    m0.arready = 1'b0; m0.rvalid = 1'b0; m0.rdata = '0; m0.rresp = '0; m0.rlast = 1'b0; m0.rid = '0;
    // the IFU never writes, so its write-side outputs stay low permanently
    m0.awready = 1'b0; m0.wready = 1'b0; m0.bvalid = 1'b0; m0.bresp = '0; m0.bid = '0;
    m1.arready = 1'b0; m1.rvalid = 1'b0; m1.rdata = '0; m1.rresp = '0; m1.rlast = 1'b0; m1.rid = '0;
    m1.awready = 1'b0; m1.wready = 1'b0; m1.bvalid = 1'b0; m1.bresp = '0; m1.bid = '0;
    case (state_q)
      RD_IFU: begin
        s.arvalid = m0.arvalid; s.araddr = m0.araddr; s.arid = m0.arid;
        s.arlen = m0.arlen; s.arsize = m0.arsize; s.arburst = m0.arburst;
        m0.arready = s.arready;
        m0.rvalid = s.rvalid; m0.rdata = s.rdata; m0.rresp = s.rresp;
        m0.rlast = s.rlast; m0.rid = s.rid;
        s.rready = m0.rready;
      end
      RD_LSU: begin
        s.arvalid = m1.arvalid; s.araddr = m1.araddr; s.arid = m1.arid;
        s.arlen = m1.arlen; s.arsize = m1.arsize; s.arburst = m1.arburst;
        m1.arready = s.arready;
        m1.rvalid = s.rvalid; m1.rdata = s.rdata; m1.rresp = s.rresp;
        m1.rlast = s.rlast; m1.rid = s.rid;
        s.rready = m1.rready;
      end
      WR_LSU: begin
        s.awvalid = m1.awvalid; s.awaddr = m1.awaddr; s.awid = m1.awid;
        s.awlen = m1.awlen; s.awsize = m1.awsize; s.awburst = m1.awburst;
        m1.awready = s.awready;
        s.wvalid = m1.wvalid; s.wdata = m1.wdata; s.wstrb = m1.wstrb; s.wlast = m1.wlast;
        m1.wready = s.wready;
        m1.bvalid = s.bvalid; m1.bresp = s.bresp; m1.bid = s.bid;
        s.bready = m1.bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060221_arbiter.sv
// Directed bench for the bus arbiter with a data scoreboard on the forwarded payloads.
// Drives one cycle at a time: inputs change 1 ns after the rising edge, outputs sampled after.
// Slave responses are scripted, so backpressure is exercised by holding ready low explicitly.
module tb_ysyx_23060221_arbiter;

  localparam int ST_IDLE = 0, ST_RD_IFU = 1, ST_RD_LSU = 2, ST_WR_LSU = 3;

  logic clk;
  logic rst;
  logic err_timeout;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q[$];

  ysyx_23060221_arbiter_if m0_if ();
  ysyx_23060221_arbiter_if m1_if ();
  ysyx_23060221_arbiter_if s_if ();

  ysyx_23060221_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) check(tag, got, exp_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    m0_if.arvalid = 0; m0_if.araddr = 0; m0_if.arid = 0; m0_if.arlen = 0; m0_if.arsize = 0; m0_if.arburst = 0;
    m0_if.rready = 0; m0_if.awvalid = 0; m0_if.awaddr = 0; m0_if.awid = 0; m0_if.awlen = 0; m0_if.awsize = 0;
    m0_if.awburst = 0; m0_if.wvalid = 0; m0_if.wdata = 0; m0_if.wstrb = 0; m0_if.wlast = 0; m0_if.bready = 0;
    m1_if.arvalid = 0; m1_if.araddr = 0; m1_if.arid = 0; m1_if.arlen = 0; m1_if.arsize = 0; m1_if.arburst = 0;
    m1_if.rready = 0; m1_if.awvalid = 0; m1_if.awaddr = 0; m1_if.awid = 0; m1_if.awlen = 0; m1_if.awsize = 0;
    m1_if.awburst = 0; m1_if.wvalid = 0; m1_if.wdata = 0; m1_if.wstrb = 0; m1_if.wlast = 0; m1_if.bready = 0;
    s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = 0; s_if.rresp = 0; s_if.rlast = 0; s_if.rid = 0;
    s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0; s_if.bresp = 0; s_if.bid = 0;
  endtask

  // Complete single-beat IFU read, checking grant latency, AR pass-through and R forwarding.
  task automatic ifu_read(input logic [31:0] addr, input logic [31:0] data, input string tag);
    m0_if.arvalid = 1; m0_if.araddr = addr; m0_if.arid = 4'h1; m0_if.arsize = 3'd2; m0_if.arburst = 2'b01;
    s_if.arready = 0;
    #1;
    check({tag, "_idle_state"}, 64'(dut.state_q), ST_IDLE);
    check({tag, "_idle_s_arvalid"}, s_if.arvalid, 0);
    tick();
    check({tag, "_grant_state"}, 64'(dut.state_q), ST_RD_IFU);
    check({tag, "_s_arvalid"}, s_if.arvalid, 1);
    check({tag, "_s_araddr"}, s_if.araddr, addr);
    check({tag, "_m0_arready_lo"}, m0_if.arready, 0);
    s_if.arready = 1;
    #1;
    check({tag, "_m0_arready_hi"}, m0_if.arready, 1);
    tick();
    m0_if.arvalid = 0; s_if.arready = 0; m0_if.rready = 1;
    s_if.rvalid = 1; s_if.rdata = data; s_if.rlast = 1; s_if.rid = 4'h1; s_if.rresp = 0;
    exp_q.push_back(data);
    #1;
    check({tag, "_m0_rvalid"}, m0_if.rvalid, 1);
    sb_check({tag, "_m0_rdata"}, m0_if.rdata);
    check({tag, "_hold_state"}, 64'(dut.state_q), ST_RD_IFU);
    tick();
    check({tag, "_release_state"}, 64'(dut.state_q), ST_IDLE);
    s_if.rvalid = 0; s_if.rlast = 0; m0_if.rready = 0;
    #1;
    check({tag, "_m0_rvalid_off"}, m0_if.rvalid, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1;
    init_inputs();
    tick();
    tick();
    check("rst_state", 64'(dut.state_q), ST_IDLE);
    check("rst_err", err_timeout, 0);
    check("rst_m0_arready", m0_if.arready, 0);
    check("rst_s_arvalid", s_if.arvalid, 0);
    rst = 0;

    // lone IFU read, granted on the first edge after reset release
    ifu_read(32'h3000_0000, 32'h0000_0413, "ifu");

    // both masters request reads together: LSU first, IFU after one bubble
    m0_if.arvalid = 1; m0_if.araddr = 32'h3000_0010; m0_if.arid = 4'h1;
    m1_if.arvalid = 1; m1_if.araddr = 32'h8000_0000; m1_if.arid = 4'h2;
    s_if.arready = 1;
    tick();
    check("dual_state_lsu", 64'(dut.state_q), ST_RD_LSU);
    check("dual_s_araddr", s_if.araddr, 32'h8000_0000);
    check("dual_s_arid", s_if.arid, 4'h2);
    check("dual_m1_arready", m1_if.arready, 1);
    check("dual_m0_arready", m0_if.arready, 0);
    tick();
    m1_if.arvalid = 0; s_if.arready = 0; m1_if.rready = 1; m0_if.rready = 1;
    s_if.rvalid = 1; s_if.rdata = 32'hCAFE_0001; s_if.rid = 4'h2; s_if.rlast = 1;
    exp_q.push_back(32'hCAFE_0001);
    #1;
    check("dual_m1_rvalid", m1_if.rvalid, 1);
    check("dual_m0_rvalid", m0_if.rvalid, 0);
    sb_check("dual_m1_rdata", m1_if.rdata);
    check("dual_m1_rid", m1_if.rid, 4'h2);
    tick();
    check("dual_bubble_state", 64'(dut.state_q), ST_IDLE);
    s_if.rvalid = 0; s_if.rlast = 0; s_if.arready = 1;
    #1;
    check("dual_bubble_m0_arready", m0_if.arready, 0);
    check("dual_bubble_s_arvalid", s_if.arvalid, 0);
    tick();
    check("dual_state_ifu", 64'(dut.state_q), ST_RD_IFU);
    check("dual_ifu_araddr", s_if.araddr, 32'h3000_0010);
    check("dual_ifu_arready", m0_if.arready, 1);
    tick();
    m0_if.arvalid = 0; s_if.arready = 0;
    // response id deliberately differs from the request id
    s_if.rvalid = 1; s_if.rdata = 32'h0000_0011; s_if.rid = 4'h7; s_if.rlast = 1;
    exp_q.push_back(32'h0000_0011);
    #1;
    sb_check("dual_m0_rdata", m0_if.rdata);
    check("dual_m0_rid_passthru", m0_if.rid, 4'h7);
    tick();
    check("dual_done_state", 64'(dut.state_q), ST_IDLE);
    init_inputs();

    // write and read requested together: write wins, read waits
    m1_if.awvalid = 1; m1_if.awaddr = 32'h8000_1000; m1_if.awid = 4'h3;
    m1_if.wvalid = 1; m1_if.wdata = 32'hDEAD_BEEF; m1_if.wstrb = 4'hF; m1_if.wlast = 1;
    exp_q.push_back(32'hDEAD_BEEF);
    m1_if.arvalid = 1; m1_if.araddr = 32'h8000_2000; m1_if.arid = 4'h4;
    s_if.awready = 1; s_if.wready = 1; s_if.arready = 1;
    #1;
    check("wr_idle_awready", m1_if.awready, 0);
    tick();
    check("wr_state", 64'(dut.state_q), ST_WR_LSU);
    check("wr_s_awvalid", s_if.awvalid, 1);
    check("wr_s_awaddr", s_if.awaddr, 32'h8000_1000);
    check("wr_m1_awready", m1_if.awready, 1);
    check("wr_m1_wready", m1_if.wready, 1);
    sb_check("wr_s_wdata", s_if.wdata);
    check("wr_s_wstrb", s_if.wstrb, 4'hF);
    check("wr_s_arvalid", s_if.arvalid, 0);
    check("wr_m1_arready", m1_if.arready, 0);
    tick();
    m1_if.awvalid = 0; m1_if.wvalid = 0;
    s_if.bvalid = 1; s_if.bid = 4'h3; m1_if.bready = 1;
    #1;
    check("wr_m1_bvalid", m1_if.bvalid, 1);
    check("wr_m1_bid", m1_if.bid, 4'h3);
    check("wr_b_s_arvalid", s_if.arvalid, 0);
    tick();
    check("wr_release_state", 64'(dut.state_q), ST_IDLE);
    check("wr_release_s_arvalid", s_if.arvalid, 0);
    s_if.bvalid = 0; m1_if.bready = 0;
    tick();
    check("pend_rd_state", 64'(dut.state_q), ST_RD_LSU);
    check("pend_rd_araddr", s_if.araddr, 32'h8000_2000);
    tick();
    // read completes while the next write is already waiting
    m1_if.arvalid = 0; s_if.arready = 0;
    m1_if.awvalid = 1; m1_if.awaddr = 32'h8000_3000; m1_if.awid = 4'h5;
    s_if.rvalid = 1; s_if.rdata = 32'h5A5A_5A5A; s_if.rlast = 1; s_if.rid = 4'h4; m1_if.rready = 1;
    exp_q.push_back(32'h5A5A_5A5A);
    #1;
    sb_check("rw_m1_rdata", m1_if.rdata);
    check("rw_rd_s_awvalid", s_if.awvalid, 0);
    tick();
    check("rw_bubble_state", 64'(dut.state_q), ST_IDLE);
    check("rw_bubble_s_awvalid", s_if.awvalid, 0);
    s_if.rvalid = 0; s_if.rlast = 0; m1_if.rready = 0;
    tick();
    check("rw_wr_state", 64'(dut.state_q), ST_WR_LSU);
    check("rw_wr_s_awvalid", s_if.awvalid, 1);

    // reset mid-write drops every handshake immediately
    s_if.bvalid = 1; m1_if.bready = 1; s_if.awready = 1;
    #1;
    check("rw_pre_rst_bvalid", m1_if.bvalid, 1);
    rst = 1;
    #1;
    check("arst_state", 64'(dut.state_q), ST_IDLE);
    check("arst_s_awvalid", s_if.awvalid, 0);
    check("arst_m1_awready", m1_if.awready, 0);
    check("arst_m1_bvalid", m1_if.bvalid, 0);
    check("arst_s_bready", s_if.bready, 0);
    init_inputs();
    rst = 0;
    ifu_read(32'h3000_0000, 32'h0000_0413, "post_rst");

    // slave never answers: timeout flag after TIMEOUT held cycles, grant kept
    m0_if.arvalid = 1; m0_if.araddr = 32'h3000_0040;
    tick();
    check("to_grant_state", 64'(dut.state_q), ST_RD_IFU);
    m0_if.arvalid = 0;
    check("to_err_start", err_timeout, 0);
    repeat (7) tick();
    check("to_err_before", err_timeout, 0);
    tick();
    check("to_err_set", err_timeout, 1);
    check("to_state_held", 64'(dut.state_q), ST_RD_IFU);
    repeat (3) tick();
    check("to_err_sticky", err_timeout, 1);
    check("to_state_still", 64'(dut.state_q), ST_RD_IFU);
    rst = 1;
    #1;
    check("to_rst_err", err_timeout, 0);
    check("to_rst_state", 64'(dut.state_q), ST_IDLE);
    rst = 0;
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
